snake_head_mover: RTL and testbench

SNAKE_HEAD_MOVER -- requirements
Module: snake_head_mover

---
 rtl/snake_pkg.sv | 44 ++++
 rtl/tick_gen.sv | 39 +++
 rtl/snake_head_mover.sv | 164 ++++++++++++++++
 tb/tb_snake_head_mover.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg
//   Shared types for the snake game blocks.
//   dir_t         : movement direction, DIR_NONE when no direction is held.
//   snake_state_t : game state IDLE / RUN / DEAD.
//   decode_dir    : maps the four direction buttons to a dir_t.
//                   Anything other than exactly one button gives DIR_NONE.
//   is_reverse    : true when two directions are exact opposites.
package snake_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_LEFT  = 3'd1,
    DIR_RIGHT = 3'd2,
    DIR_UP    = 3'd3,
    DIR_DOWN  = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } snake_state_t;

  function automatic dir_t decode_dir(input logic left, input logic right,
                                      input logic up, input logic down);
    dir_t d;
    case ({left, right, up, down})
      4'b1000: d = DIR_LEFT;
      4'b0100: d = DIR_RIGHT;
      4'b0010: d = DIR_UP;
      4'b0001: d = DIR_DOWN;
      default: d = DIR_NONE;
    endcase
    return d;
  endfunction

  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return ((a == DIR_LEFT)  && (b == DIR_RIGHT)) ||
           ((a == DIR_RIGHT) && (b == DIR_LEFT))  ||
           ((a == DIR_UP)    && (b == DIR_DOWN))  ||
           ((a == DIR_DOWN)  && (b == DIR_UP));
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen
//   Move-rate divider. Counts 0..TICK_DIV-1 while enabled and emits a
//   one-cycle tick in the cycle the count sits at TICK_DIV-1 (the count
//   wraps to 0 at the end of that cycle). When not enabled the count holds.
//   Ports:
//     clk    : clock
//     reset  : asynchronous active-low reset, count -> 0
//     enable : advance the count this cycle
//     clear  : force the count to 0 (overrides enable)
//     tick   : step request, high in the wrap cycle
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= (count_reg == LAST) ? '0 : count_reg + CW'(1);
    end
  end

  // Gated by enable so a held (paused) count never re-issues a step.
  assign tick = enable && (count_reg == LAST);

endmodule

// File: rtl/snake_head_mover.sv
// snake_head_mover
//   Moves the snake head one cell per TICK_DIV clocks in the last accepted
//   direction; hitting a wall ends the game until restart.
//   Ports:
//     clk                    : clock
//     reset                  : asynchronous active-low reset
//     left/right/up/down     : one-hot direction buttons (level)
//     pause                  : freezes movement while high
//     restart                : leaves DEAD back to IDLE
//     head_x, head_y         : head position, (0,0) is top-left
//     moved                  : one-cycle pulse per completed step
//     running, dead          : state flags
//     step_count             : steps since leaving IDLE, saturating
module snake_head_mover
  import snake_pkg::*;
#(
  parameter int GRID_W   = 16,
  parameter int GRID_H   = 16,
  parameter int TICK_DIV = 25000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      left,
  input  logic                      right,
  input  logic                      up,
  input  logic                      down,
  input  logic                      pause,
  input  logic                      restart,
  output logic [$clog2(GRID_W)-1:0] head_x,
  output logic [$clog2(GRID_H)-1:0] head_y,
  output logic                      moved,
  output logic                      running,
  output logic                      dead,
  output logic [15:0]               step_count
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam logic [XW-1:0] X_MID = XW'(GRID_W / 2);
  localparam logic [YW-1:0] Y_MID = YW'(GRID_H / 2);
  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

  snake_state_t  state_reg, state_next;
  dir_t          cur_dir_reg, cur_dir_next;
  logic [XW-1:0] head_x_reg, head_x_next;
  logic [YW-1:0] head_y_reg, head_y_next;
  logic [15:0]   step_count_reg, step_count_next;
  logic          moved_reg, moved_next;
  logic          running_reg, running_next;
  logic          dead_reg, dead_next;

  dir_t dir_in;
  logic tick;
  logic at_edge;

  assign dir_in = decode_dir(left, right, up, down);

  // The counter only runs in RUN; outside RUN it is held at 0 so entering
  // RUN (from IDLE) always starts a fresh full period.
  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable ((state_reg == RUN) && !pause),
    .clear  (state_reg != RUN),
    .tick   (tick)
  );

  // Wall test uses the registered direction: a direction pressed in the
  // step cycle only takes effect from the following step.
  assign at_edge = ((cur_dir_reg == DIR_LEFT)  && (head_x_reg == '0))   ||
                   ((cur_dir_reg == DIR_RIGHT) && (head_x_reg == X_MAX)) ||
                   ((cur_dir_reg == DIR_UP)    && (head_y_reg == '0))   ||
                   ((cur_dir_reg == DIR_DOWN)  && (head_y_reg == Y_MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cur_dir_reg    <= DIR_NONE;
      head_x_reg     <= X_MID;
      head_y_reg     <= Y_MID;
      step_count_reg <= '0;
      moved_reg      <= 1'b0;
      running_reg    <= 1'b0;
      dead_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cur_dir_reg    <= cur_dir_next;
      head_x_reg     <= head_x_next;
      head_y_reg     <= head_y_next;
      step_count_reg <= step_count_next;
      moved_reg      <= moved_next;
      running_reg    <= running_next;
      dead_reg       <= dead_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cur_dir_next    = cur_dir_reg;
    head_x_next     = head_x_reg;
    head_y_next     = head_y_reg;
    step_count_next = step_count_reg;
    moved_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (dir_in != DIR_NONE) begin
          state_next   = RUN;
          cur_dir_next = dir_in;
        end
      end

      RUN: begin
        if ((dir_in != DIR_NONE) && !is_reverse(dir_in, cur_dir_reg)) begin
          cur_dir_next = dir_in;
        end
        if (tick) begin
          if (at_edge) begin
            state_next = DEAD;
          end else begin
            moved_next = 1'b1;
            if (step_count_reg != 16'hFFFF) begin
              step_count_next = step_count_reg + 16'd1;
            end
            case (cur_dir_reg)
              DIR_LEFT:  head_x_next = head_x_reg - XW'(1);
              DIR_RIGHT: head_x_next = head_x_reg + XW'(1);
              DIR_UP:    head_y_next = head_y_reg - YW'(1);
              DIR_DOWN:  head_y_next = head_y_reg + YW'(1);
              default:   ;
            endcase
          end
        end
      end

      DEAD: begin
        if (restart) begin
          state_next      = IDLE;
          cur_dir_next    = DIR_NONE;
          head_x_next     = X_MID;
          head_y_next     = Y_MID;
          step_count_next = '0;
        end
      end

      default: state_next = IDLE;
    endcase

    // Flags follow the next state so they change on the same edge as it.
    running_next = (state_next == RUN);
    dead_next    = (state_next == DEAD);
  end

  assign head_x     = head_x_reg;
  assign head_y     = head_y_reg;
  assign moved      = moved_reg;
  assign running    = running_reg;
  assign dead       = dead_reg;
  assign step_count = step_count_reg;

endmodule

// File: tb/tb_snake_head_mover.sv
// tb_snake_head_mover
//   Directed bench for snake_head_mover with a 16x16 grid and TICK_DIV=4.
//   Inputs change 1 time unit after a rising edge; outputs are checked at
//   the same point, i.e. they reflect the state registered on that edge.
module tb_snake_head_mover;

  logic        clk = 1'b0;
  logic        reset;
  logic        left, right, up, down, pause, restart;
  logic [3:0]  head_x, head_y;
  logic        moved, running, dead;
  logic [15:0] step_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snake_head_mover #(
    .GRID_W   (16),
    .GRID_H   (16),
    .TICK_DIV (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .left       (left),
    .right      (right),
    .up         (up),
    .down       (down),
    .pause      (pause),
    .restart    (restart),
    .head_x     (head_x),
    .head_y     (head_y),
    .moved      (moved),
    .running    (running),
    .dead       (dead),
    .step_count (step_count)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
      $display("check %-22s observed %0d expected %0d", tag, obs, exp);
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    {left, right, up, down, pause, restart} = '0;

    // Reset state
    clocks(2);
    check("reset_x", head_x, 8);
    check("reset_y", head_y, 8);
    check("reset_running", running, 0);
    check("reset_dead", dead, 0);
    check("reset_moved", moved, 0);
    check("reset_steps", step_count, 0);

    // No start without a valid direction
    reset = 1'b1;
    clocks(3);
    check("idle_no_dir", running, 0);
    left = 1'b1; right = 1'b1;
    clocks(1);
    check("idle_two_dirs", running, 0);
    left = 1'b0;

    // Start right: counter 0..3, step on the 4th RUN cycle
    clocks(1);
    right = 1'b0;
    check("start_running", running, 1);
    clocks(3);
    check("start_no_move_yet", moved, 0);
    check("start_x_hold", head_x, 8);
    clocks(1);
    check("start_moved", moved, 1);
    check("start_x", head_x, 9);
    check("start_steps", step_count, 1);

    // Reverse is dropped
    clocks(4);
    check("pre_rev_x", head_x, 10);
    left = 1'b1;
    clocks(1);
    left = 1'b0;
    check("rev_moved_low", moved, 0);
    clocks(3);
    check("rev_x", head_x, 11);
    check("rev_steps", step_count, 3);

    // Run into the right wall
    right = 1'b1;
    for (int i = 12; i <= 15; i++) begin
      clocks(4);
      check($sformatf("wall_x_%0d", i), head_x, i);
    end
    check("wall_steps", step_count, 7);
    for (int i = 0; i < 4; i++) begin
      clocks(1);
      check($sformatf("wall_moved_%0d", i), moved, 0);
    end
    check("wall_dead", dead, 1);
    check("wall_running", running, 0);
    check("wall_x", head_x, 15);
    check("wall_steps_hold", step_count, 7);

    // DEAD ignores directions and pause
    right = 1'b0; up = 1'b1; pause = 1'b1;
    clocks(8);
    check("dead_hold_x", head_x, 15);
    check("dead_hold_y", head_y, 8);
    check("dead_hold", dead, 1);
    up = 1'b0; pause = 1'b0;

    // Restart
    restart = 1'b1;
    clocks(1);
    restart = 1'b0;
    check("restart_dead", dead, 0);
    check("restart_running", running, 0);
    check("restart_x", head_x, 8);
    check("restart_y", head_y, 8);
    check("restart_steps", step_count, 0);

    // Up with pause at counter = 2
    up = 1'b1;
    clocks(1);
    check("up_running", running, 1);
    clocks(2);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      restart = (i == 4);
      clocks(1);
      check($sformatf("pause_moved_%0d", i), moved, 0);
    end
    restart = 1'b0;
    check("pause_y", head_y, 8);
    check("pause_restart_ign", running, 1);
    pause = 1'b0;
    clocks(1);
    check("resume_moved_early", moved, 0);
    clocks(1);
    check("resume_moved", moved, 1);
    check("resume_y", head_y, 7);
    check("resume_steps", step_count, 1);

    // Direction change in the step cycle applies from the next step
    clocks(3);
    up = 1'b0; left = 1'b1;
    clocks(1);
    left = 1'b0;
    check("stepcyc_y", head_y, 6);
    check("stepcyc_x", head_x, 8);
    clocks(4);
    check("turn_x", head_x, 7);
    check("turn_y", head_y, 6);
    check("turn_steps", step_count, 3);

    // Reset mid-RUN, right before a step
    clocks(3);
    #2;
    reset = 1'b0;
    #1;
    check("rst_running", running, 0);
    check("rst_x", head_x, 8);
    check("rst_y", head_y, 8);
    check("rst_steps", step_count, 0);
    clocks(1);
    reset = 1'b1;
    clocks(1);
    check("rst_no_moved", moved, 0);
    clocks(4);
    check("rst_idle", running, 0);
    check("rst_idle_x", head_x, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
